// File: rtl/currctrl_debug_capture.sv
// Pre/post-trigger sample logger for the current-control debug RAM.
// Decimates loop samples and writes them circularly into RAM port 2.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   arm, abort        capture start (IDLE/DONE only) and unconditional stop
//   trigger           trigger qualifier, honoured in WAIT
//   pretrig_len       pre-trigger sample count, latched on arm
//   decim             keep 1 of decim+1 valid samples, latched on arm
//   sample_valid/data sample stream from the current-control loop
//   ram_*             RAM port-2 write interface (registered)
//   busy              capture in progress (PRE, WAIT, POST)
//   capture_done      buffer complete, level
//   trig_addr         address of the first post-trigger sample
//   start_addr        address of the oldest valid sample
module currctrl_debug_capture #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trigger,
    input  logic [ADDR_WIDTH-1:0]  pretrig_len,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic                   sample_valid,
    input  logic [DATA_WIDTH-1:0]  sample_data,
    output logic                   ram_chipselect,
    output logic                   ram_write,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0]  ram_writedata,
    output logic [3:0]             ram_byteenable,
    output logic                   busy,
    output logic                   capture_done,
    output logic [ADDR_WIDTH-1:0]  trig_addr,
    output logic [ADDR_WIDTH-1:0]  start_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                 state_q, state_d;
    logic [1:0]             rst_sync_q;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [ADDR_WIDTH-1:0]  precnt_q, precnt_d;
    logic [ADDR_WIDTH:0]    postcnt_q, postcnt_d;
    logic [ADDR_WIDTH-1:0]  plen_q, plen_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [ADDR_WIDTH-1:0]  trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0]  start_addr_q, start_addr_d;
    logic                   done_q, done_d;
    logic                   ram_write_q, ram_write_d;
    logic [ADDR_WIDTH-1:0]  ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0]  ram_writedata_q, ram_writedata_d;

    logic                   active;
    logic                   accept;
    logic                   arm_ok;
    logic [ADDR_WIDTH:0]    post_init;

    // Deassertion of reset is delayed two edges before arm is honoured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign active    = (state_q == S_PRE) || (state_q == S_WAIT) ||
                       (state_q == S_POST);
    assign accept    = active && sample_valid && (dcnt_q == '0);
    assign arm_ok    = arm && !abort && !rst_sync_q[1] &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));
    assign post_init = DEPTH - {1'b0, plen_q};

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        dcnt_d          = dcnt_q;
        precnt_d        = precnt_q;
        postcnt_d       = postcnt_q;
        plen_d          = plen_q;
        decim_d         = decim_q;
        trig_addr_d     = trig_addr_q;
        start_addr_d    = start_addr_q;
        done_d          = done_q;
        ram_write_d     = 1'b0;
        ram_address_d   = ram_address_q;
        ram_writedata_d = ram_writedata_q;

        if (active && sample_valid) begin
            dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_WIDTH'(1);
        end

        if (accept) begin
            ram_write_d     = 1'b1;
            ram_address_d   = wr_ptr_q;
            ram_writedata_d = sample_data;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end

        unique case (state_q)
            S_PRE: begin
                if (accept) begin
                    precnt_d = precnt_q + ADDR_WIDTH'(1);
                    if (precnt_d == plen_q) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (trigger) begin
                    trig_addr_d = wr_ptr_q;
                    // A sample accepted now is the first post-trigger one.
                    if (accept) begin
                        postcnt_d = post_init - (ADDR_WIDTH+1)'(1);
                        state_d   = (post_init == (ADDR_WIDTH+1)'(1)) ?
                                    S_DONE : S_POST;
                    end else begin
                        postcnt_d = post_init;
                        state_d   = S_POST;
                    end
                end
            end
            S_POST: begin
                if (accept) begin
                    postcnt_d = postcnt_q - (ADDR_WIDTH+1)'(1);
                    if (postcnt_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Published one cycle after entry, once the last write lands.
                done_d       = 1'b1;
                start_addr_d = trig_addr_q - plen_q;
            end
            default: begin
            end
        endcase

        if (arm_ok) begin
            plen_d       = pretrig_len;
            decim_d      = decim;
            wr_ptr_d     = '0;
            dcnt_d       = '0;
            precnt_d     = '0;
            done_d       = 1'b0;
            trig_addr_d  = '0;
            start_addr_d = '0;
            state_d      = (pretrig_len == '0) ? S_WAIT : S_PRE;
        end

        if (abort) begin
            state_d         = S_IDLE;
            done_d          = 1'b0;
            ram_write_d     = 1'b0;
            ram_address_d   = ram_address_q;
            ram_writedata_d = ram_writedata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            dcnt_q          <= '0;
            precnt_q        <= '0;
            postcnt_q       <= '0;
            plen_q          <= '0;
            decim_q         <= '0;
            trig_addr_q     <= '0;
            start_addr_q    <= '0;
            done_q          <= 1'b0;
            ram_write_q     <= 1'b0;
            ram_address_q   <= '0;
            ram_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            dcnt_q          <= dcnt_d;
            precnt_q        <= precnt_d;
            postcnt_q       <= postcnt_d;
            plen_q          <= plen_d;
            decim_q         <= decim_d;
            trig_addr_q     <= trig_addr_d;
            start_addr_q    <= start_addr_d;
            done_q          <= done_d;
            ram_write_q     <= ram_write_d;
            ram_address_q   <= ram_address_d;
            ram_writedata_q <= ram_writedata_d;
        end
    end

    assign ram_write      = ram_write_q;
    assign ram_chipselect = ram_write_q;
    assign ram_byteenable = {4{ram_write_q}};
    assign ram_address    = ram_address_q;
    assign ram_writedata  = ram_writedata_q;
    assign busy           = active;
    assign capture_done   = done_q;
    assign trig_addr      = trig_addr_q;
    assign start_addr     = start_addr_q;

endmodule

// File: tb/tb_currctrl_debug_capture.sv
// Self-checking bench for currctrl_debug_capture.
// Expected write streams come from a per-capture sample-list model.
module tb_currctrl_debug_capture;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DCW   = 8;
    localparam int DEPTH = 512;
    localparam int MAXC  = 6000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic           trigger = 1'b0;
    logic [AW-1:0]  pretrig_len = '0;
    logic [DCW-1:0] decim = '0;
    logic           sample_valid = 1'b0;
    logic [DW-1:0]  sample_data = '0;
    logic           ram_chipselect;
    logic           ram_write;
    logic [AW-1:0]  ram_address;
    logic [DW-1:0]  ram_writedata;
    logic [3:0]     ram_byteenable;
    logic           busy;
    logic           capture_done;
    logic [AW-1:0]  trig_addr;
    logic [AW-1:0]  start_addr;

    int checks = 0;
    int failures = 0;

    logic          vld [MAXC];
    logic [DW-1:0] dat [MAXC];
    logic          trg [MAXC];
    logic          ewr [MAXC+8];
    logic [AW-1:0] eaddr [MAXC+8];
    logic [DW-1:0] edata [MAXC+8];
    int m_last, m_trig, m_start, m_nwr, o_nwr;

    currctrl_debug_capture #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DECIM_WIDTH(DCW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .trigger       (trigger),
        .pretrig_len   (pretrig_len),
        .decim         (decim),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .ram_chipselect(ram_chipselect),
        .ram_write     (ram_write),
        .ram_address   (ram_address),
        .ram_writedata (ram_writedata),
        .ram_byteenable(ram_byteenable),
        .busy          (busy),
        .capture_done  (capture_done),
        .trig_addr     (trig_addr),
        .start_addr    (start_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"}, 64'(ram_write), 64'(0));
        chk({tag, "_cs"}, 64'(ram_chipselect), 64'(0));
        chk({tag, "_be"}, 64'(ram_byteenable), 64'(0));
        chk({tag, "_addr"}, 64'(ram_address), 64'(0));
        chk({tag, "_data"}, 64'(ram_writedata), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(capture_done), 64'(0));
        chk({tag, "_trig"}, 64'(trig_addr), 64'(0));
        chk({tag, "_start"}, 64'(start_addr), 64'(0));
    endtask

    // Cycle 0 is the first cycle after arm. From the stimulus, list the
    // kept samples, locate the trigger and derive the write stream.
    task automatic build(input int plen, input int dec, input int vmode,
                         input int tmode, input int tparam,
                         input int stop_c);
        int vi = 0;
        int vcount = 0;
        int nacc = 0;
        int wstart;
        int postleft = 0;
        bit tseen = 1'b0;
        m_last = -1;
        m_trig = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (vmode == 0) vld[c] = 1'b1;
            else if (vmode == 1) vld[c] = (c % 2 == 0);
            else vld[c] = ($urandom_range(0, 3) != 0);
            trg[c] = (tmode == 0) ? (c == tparam) : (c >= tparam);
            if (vmode == 2 || !vld[c]) dat[c] = $urandom;
            else dat[c] = vi;
            if (vld[c]) vi++;
        end
        for (int c = 0; c < MAXC + 8; c++) begin
            ewr[c] = 1'b0;
            eaddr[c] = '0;
            edata[c] = '0;
        end
        wstart = (plen == 0) ? 0 : -1;
        for (int c = 0; c < MAXC; c++) begin
            if (c == stop_c) break;
            if (wstart >= 0 && c >= wstart && !tseen && trg[c]) begin
                tseen = 1'b1;
                m_trig = nacc % DEPTH;
                postleft = DEPTH - plen;
            end
            if (vld[c]) begin
                if (vcount % (dec + 1) == 0) begin
                    ewr[c+1] = 1'b1;
                    eaddr[c+1] = AW'(nacc % DEPTH);
                    edata[c+1] = dat[c];
                    nacc++;
                    if (wstart < 0 && nacc == plen) wstart = c + 1;
                    if (tseen) begin
                        postleft--;
                        if (postleft == 0) begin
                            m_last = c;
                            break;
                        end
                    end
                end
                vcount++;
            end
        end
        m_nwr = nacc;
        m_start = (m_trig - plen + DEPTH) % DEPTH;
    endtask

    task automatic run_cap(input string nm, input int plen, input int dec,
                           input int vmode, input int tmode,
                           input int tparam, input int abort_c,
                           input int rst_c, input int armp_c);
        int stop_c = (abort_c >= 0) ? abort_c : rst_c;
        int end_c;
        int nwr = 0;
        bit exp_busy;
        bit exp_done;
        build(plen, dec, vmode, tmode, tparam, stop_c);
        if (stop_c >= 0) end_c = stop_c + 4;
        else if (m_last >= 0) end_c = m_last + 4;
        else end_c = MAXC;
        if (end_c > MAXC) end_c = MAXC;
        @(negedge clk);
        arm = 1'b1;
        abort = 1'b0;
        pretrig_len = AW'(plen);
        decim = DCW'(dec);
        trigger = (tmode == 1 && tparam <= 0);
        sample_valid = 1'b1;
        sample_data = $urandom;
        for (int c = 0; c < end_c; c++) begin
            @(negedge clk);
            arm = (c == armp_c);
            abort = (c == abort_c);
            pretrig_len = AW'($urandom);
            decim = DCW'($urandom);
            sample_valid = vld[c];
            sample_data = dat[c];
            trigger = trg[c];
            if (ram_write) nwr++;
            chk({nm, "_wr"}, 64'(ram_write), 64'(ewr[c]));
            chk({nm, "_cs"}, 64'(ram_chipselect), 64'(ewr[c]));
            chk({nm, "_be"}, 64'(ram_byteenable),
                64'(ewr[c] ? 4'hF : 4'h0));
            if (ewr[c]) begin
                chk({nm, "_addr"}, 64'(ram_address), 64'(eaddr[c]));
                chk({nm, "_data"}, 64'(ram_writedata), 64'(edata[c]));
            end
            if (stop_c >= 0) exp_busy = (c <= stop_c);
            else exp_busy = (m_last < 0) || (c <= m_last);
            exp_done = (stop_c < 0) && (m_last >= 0) && (c >= m_last + 2);
            chk({nm, "_busy"}, 64'(busy), 64'(exp_busy));
            chk({nm, "_done"}, 64'(capture_done), 64'(exp_done));
            if (c == 0) begin
                chk({nm, "_trig_clr"}, 64'(trig_addr), 64'(0));
                chk({nm, "_start_clr"}, 64'(start_addr), 64'(0));
            end
            if (stop_c < 0 && c == m_last + 2) begin
                chk({nm, "_trig"}, 64'(trig_addr), 64'(m_trig));
                chk({nm, "_start"}, 64'(start_addr), 64'(m_start));
            end
            if (c == rst_c) begin
                reset = 1'b1;
                #1;
                chk_zero({nm, "_rst"});
                break;
            end
        end
        arm = 1'b0;
        abort = 1'b0;
        sample_valid = 1'b0;
        trigger = 1'b0;
        chk({nm, "_nwr"}, 64'(nwr), 64'(m_nwr));
        o_nwr = nwr;
        if (rst_c >= 0) begin
            @(negedge clk);
            reset = 1'b0;
            repeat (4) @(negedge clk);
            chk({nm, "_idle"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_cap("basic", 4, 0, 0, 0, 10, -1, -1, -1);
        chk("basic_trig_k", 64'(trig_addr), 64'(10));
        chk("basic_start_k", 64'(start_addr), 64'(6));
        chk("basic_nwr_k", 64'(o_nwr), 64'(518));

        run_cap("decim", 5, 2, 0, 1, 40, -1, -1, -1);

        run_cap("pregate", 8, 0, 0, 1, 0, -1, -1, -1);
        chk("pregate_trig_k", 64'(trig_addr), 64'(8));

        run_cap("zeropre", 0, 0, 0, 1, 0, -1, -1, -1);
        chk("zeropre_trig_k", 64'(trig_addr), 64'(0));
        chk("zeropre_start_k", 64'(start_addr), 64'(0));
        chk("zeropre_nwr_k", 64'(o_nwr), 64'(512));

        run_cap("sparse", 6, 0, 1, 0, 30, -1, -1, -1);

        run_cap("abort", 3, 0, 0, 0, -5, 20, -1, -1);

        @(negedge clk);
        arm = 1'b1;
        abort = 1'b1;
        pretrig_len = AW'(2);
        decim = '0;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            arm = 1'b0;
            abort = 1'b0;
            chk("armabort_busy", 64'(busy), 64'(0));
            chk("armabort_wr", 64'(ram_write), 64'(0));
        end
        sample_valid = 1'b0;

        run_cap("armpost", 10, 0, 0, 0, 30, -1, -1, 60);
        run_cap("rstpost", 4, 0, 0, 0, 10, -1, 100, -1);
        run_cap("afterrst", 2, 0, 0, 0, 5, -1, -1, -1);

        for (int r = 0; r < 4; r++) begin
            run_cap("rand", int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 2)), 2, 1,
                    int'($urandom_range(0, 300)), -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/currctrl_debug_capture.md
# currctrl_debug_capture

Pre/post-trigger sample logger for the current-control debug path. Takes the per-sample word from the current-control loop, decimates it, and writes it as a circular buffer into the second (write) port of the 512×32 current-control debug RAM. The CPU reads the buffer back through the RAM's first Avalon port once `capture_done` is high. The block reports the trigger address and the oldest-sample address so firmware can unroll the buffer.

## Interface
- `ADDR_WIDTH`, 9, RAM word-address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32, sample and RAM word width.
- `DECIM_WIDTH`, 8, width of the decimation setting.

- `clk`  in  1  single clock for the block and RAM port 2.
- `reset`  in  1  asynchronous, active-high reset.
- `arm`  in  1  start-capture pulse; accepted in IDLE or DONE only.
- `abort`  in  1  return to IDLE from any state.
- `trigger`  in  1  trigger qualifier, sampled each cycle.
- `pretrig_len`  in  ADDR_WIDTH  number of pre-trigger samples; latched on accepted `arm`.
- `decim`  in  DECIM_WIDTH  keep 1 of every `decim`+1 valid samples; latched on accepted `arm`.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  DATA_WIDTH  {setpoint[15:0], measured[15:0]}.
- `ram_chipselect`  out  1  RAM port-2 chip select; identical to `ram_write`.
- `ram_write`  out  1  RAM port-2 write strobe.
- `ram_address`  out  ADDR_WIDTH  RAM port-2 word address.
- `ram_writedata`  out  DATA_WIDTH  RAM port-2 write data.
- `ram_byteenable`  out  4  4'hF while writing, 4'h0 otherwise.
- `busy`  out  1  high in PRE, WAIT and POST.
- `capture_done`  out  1  buffer complete; level output.
- `trig_addr`  out  ADDR_WIDTH  address of the first post-trigger sample.
- `start_addr`  out  ADDR_WIDTH  address of the oldest valid sample.

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. After reset the block is in IDLE and every output is 0.
- **Accepting `arm` (in IDLE or DONE):**
  - Latch `pretrig_len` and `decim`.
  - Clear `wr_ptr`, the decimation counter, the pre-counter and `capture_done`.
  - Go to PRE, or go directly to WAIT if `pretrig_len` = 0.
- **Accepted sample:** in PRE, WAIT or POST, `sample_valid` is high and the decimation counter is 0.
  - The decimation counter advances on every valid sample and wraps after the latched `decim`.
  - With `decim` = 0, every valid sample is accepted.
- **Writing an accepted sample:**
  - Registered write to address `wr_ptr`.
  - `wr_ptr` increments modulo 2^ADDR_WIDTH (511→0 wrap).
- **PRE:** count writes. After the `pretrig_len`-th write, go to WAIT. `trigger` is ignored in PRE.
- **WAIT:** circular writes continue. If `trigger` is high:
  - `trig_addr` ← current `wr_ptr`.
  - Post-counter ← 2^ADDR_WIDTH − latched `pretrig_len` (range 1..512).
  - Go to POST.
  - A sample accepted in the trigger cycle is written at `trig_addr` and counts as the first post-trigger sample.
- **POST:** decrement the post-counter per accepted sample. The last write moves the block to DONE.
  - `start_addr` ← `trig_addr` − latched `pretrig_len` (mod 2^ADDR_WIDTH).
  - The buffer then holds exactly 2^ADDR_WIDTH valid words.
- **DONE:** no writes. `capture_done` stays high until an accepted `arm` or `abort`.
- **`abort`:**
  - Go to IDLE on the next edge and clear `capture_done`.
  - Suppress any write pending from the abort cycle.
  - RAM contents are untouched.
- **Priority:** `abort` > `arm`. `arm` in PRE, WAIT or POST is ignored.
- **Outputs outside a write:** `ram_address` and `ram_writedata` hold their last values; `ram_write`, `ram_chipselect` and `ram_byteenable` are 0.
- `trig_addr` and `start_addr` hold their values until the next accepted `arm`, which clears them to 0.

## Timing
- **Arm:** `arm` at cycle N → `busy` = 1 and samples accepted from cycle N+1.
- **Write latency:** sample accepted at cycle k → `ram_write` high during cycle k+1, with `ram_address`/`ram_writedata` valid. The RAM commits on the edge ending k+1.
- **Throughput:** one sample per cycle, sustained with no gaps.
- **Trigger:** `trigger` in WAIT at cycle t → POST from t+1. A trigger is never lost if a sample is accepted in the same cycle.
- **Completion:** final post-trigger sample accepted at k.
  - State DONE and `busy` = 0 at k+1.
  - `capture_done`, `trig_addr` and `start_addr` valid at k+2, after the final write has committed.
- **Reset:** asynchronous assertion at any point forces IDLE and all outputs to 0 immediately. Deassertion is synchronised internally; first `arm` is honoured two cycles after deassertion.

## Test plan
- **Basic capture:** `pretrig_len`=4, `decim`=0, continuous valid with data = running index, `trigger` asserted with the 11th sample → `trig_addr`=10, 518 writes with addresses wrapping 511→0, `start_addr`=6, RAM[6..9] = 6..9, `capture_done` two cycles after the last write.
- **Decimation:** `decim`=2, data = index → writes carry 0, 3, 6, …, `ram_write` exactly one cycle in three, `byteenable`=4'hF only on write cycles.
- **Trigger gating and zero pre-trigger:**
  - `trigger` held high throughout PRE with `pretrig_len`=8 → trigger ignored until 8 writes, then `trig_addr`=8.
  - `pretrig_len`=0 with `trigger` already high at arm → `trig_addr`=0, 512 writes, `start_addr`=0.
- **Sparse valid:** `sample_valid` toggling 1-0-1-0 with `trigger` coinciding with a valid sample → that sample is written at `trig_addr`, and `capture_done` follows exactly 2^ADDR_WIDTH − `pretrig_len` accepted samples after the trigger.
- **Control conflicts:**
  - `abort` mid-WAIT → IDLE next cycle, no further writes.
  - `arm`+`abort` in the same cycle → stays IDLE.
  - `arm` during POST → ignored, capture completes normally.
  - `arm` in DONE → `capture_done` cleared, new capture starts.
- **Reset mid-operation:** `reset` pulsed during POST while `ram_write`=1 → all outputs 0 immediately, IDLE; a later capture runs correctly from address 0.
